// File: rtl/lfsr_share_ctrl.sv
// lfsr_share_ctrl: 4-bit XOR-feedback LFSR with seed loading and a warm-up
// phase. It shares fresh nibbles between two requesters by round-robin.
// Each grant consumes exactly one LFSR step, so the two requesters never
// receive the same value.
module lfsr_share_ctrl #(
    parameter logic [3:0]  SEED   = 4'b1111,
    parameter int unsigned WARMUP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_load,
    input  logic [3:0] seed_val,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [3:0] rnd,
    output logic       rnd_valid,
    output logic       busy
);

    typedef enum logic {WARM, READY} state_t;

    // With a zero warm-up length the WARM state is skipped entirely.
    localparam state_t     INIT_ST = (WARMUP == 0) ? READY : WARM;
    localparam logic [4:0] WARM_N  = 5'(WARMUP);

    state_t     state;
    logic [3:0] lfsr;
    logic [3:0] warm_cnt;
    logic       ptr;
    logic       sel;
    logic       warm_done;

    function automatic logic [3:0] lfsr_step(input logic [3:0] q);
        return {q[2], q[1], q[3] ^ q[0], q[3]};
    endfunction

    // Requester to grant: the only one asking, or the one ptr prefers.
    always_comb begin
        sel       = req[1] & (~req[0] | ptr);
        warm_done = ({1'b0, warm_cnt} + 5'd1) == WARM_N;
    end

    // Controller FSM, LFSR, arbitration pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT_ST;
            lfsr      <= SEED;
            warm_cnt  <= 4'd0;
            ptr       <= 1'b0;
            gnt       <= 2'b00;
            rnd       <= 4'h0;
            rnd_valid <= 1'b0;
        end else begin
            gnt       <= 2'b00;
            rnd_valid <= 1'b0;
            if (seed_load) begin
                // Zero would lock up the LFSR, so it is replaced by SEED.
                lfsr     <= (seed_val == 4'h0) ? SEED : seed_val;
                warm_cnt <= 4'd0;
                state    <= INIT_ST;
            end else begin
                case (state)
                    WARM: begin
                        lfsr     <= lfsr_step(lfsr);
                        warm_cnt <= warm_cnt + 4'd1;
                        if (warm_done)
                            state <= READY;
                    end
                    READY: begin
                        if (|req) begin
                            gnt       <= sel ? 2'b10 : 2'b01;
                            rnd       <= lfsr;
                            rnd_valid <= 1'b1;
                            lfsr      <= lfsr_step(lfsr);
                            ptr       <= ~sel;
                        end
                    end
                    default: state <= INIT_ST;
                endcase
            end
        end
    end

    assign busy = (state == WARM);

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Scoreboard bench for lfsr_share_ctrl: a driver steps a behavioural model
// and queues expected grants; a monitor checks every DUT output cycle.
module tb_lfsr_share_ctrl;

    localparam logic [3:0] SEED   = 4'b1111;
    localparam int         WARMUP = 4;

    logic       clk = 1'b0;
    logic       rst, seed_load;
    logic [3:0] seed_val;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [3:0] rnd;
    logic       rnd_valid, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] g;
        logic [3:0] r;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [3:0] m_lfsr;
    int         m_warm;
    int         m_ptr;
    logic [3:0] m_rnd;

    lfsr_share_ctrl #(.SEED(SEED), .WARMUP(WARMUP)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_val(seed_val),
        .req(req), .gnt(gnt), .rnd(rnd), .rnd_valid(rnd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Rotate left by one, then fold the old top bit into bit 1.
    function automatic logic [3:0] nxt(input logic [3:0] v);
        int x, r;
        x = int'(v);
        r = ((x << 1) | (x >> 3)) & 15;
        r = r ^ ((x >> 3) << 1);
        return 4'(r);
    endfunction

    // Drive one cycle of inputs, predict the edge, then check busy.
    task automatic cycle(input logic r, input logic sl, input logic [3:0] sv,
                         input logic [1:0] rq);
        rst = r; seed_load = sl; seed_val = sv; req = rq;
        if (r) begin
            m_lfsr = SEED; m_warm = WARMUP; m_ptr = 0; m_rnd = 4'h0;
        end else if (sl) begin
            m_lfsr = (sv == 4'h0) ? SEED : sv;
            m_warm = WARMUP;
        end else if (m_warm > 0) begin
            m_lfsr = nxt(m_lfsr);
            m_warm--;
        end else if (rq != 2'b00) begin
            int i;
            i = (rq == 2'b11) ? m_ptr : ((rq == 2'b10) ? 1 : 0);
            exp_q.push_back('{g: 2'(1 << i), r: m_lfsr});
            m_rnd  = m_lfsr;
            m_lfsr = nxt(m_lfsr);
            m_ptr  = 1 - i;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== (m_warm > 0)) begin
            errors++;
            $display("FAIL busy: got %b want %b at %0t", busy, (m_warm > 0), $time);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 4'h0, 2'b00);
    endtask

    task automatic hold(input logic [1:0] rq, input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 4'h0, rq);
    endtask

    // Monitor: compares every post-edge output against the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (rnd_valid !== (gnt != 2'b00)) begin
            errors++;
            $display("FAIL valid_vs_gnt: rnd_valid=%b gnt=%b at %0t", rnd_valid, gnt, $time);
        end
        if (rnd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: gnt=%b rnd=%b at %0t", gnt, rnd, $time);
            end else begin
                e = exp_q.pop_front();
                if (gnt !== e.g || rnd !== e.r) begin
                    errors++;
                    $display("FAIL grant: got gnt=%b rnd=%b want gnt=%b rnd=%b at %0t",
                             gnt, rnd, e.g, e.r, $time);
                end
            end
        end else begin
            checks++;
            if (gnt !== 2'b00) begin
                errors++;
                $display("FAIL idle_gnt: got %b want 00 at %0t", gnt, $time);
            end
        end
        checks++;
        if (rnd !== m_rnd) begin
            errors++;
            $display("FAIL rnd_hold: got %b want %b at %0t", rnd, m_rnd, $time);
        end
        if (exp_q.size() > 1) begin
            checks++;
            errors++;
            $display("FAIL missing_grant: %0d expected grants outstanding at %0t",
                     exp_q.size(), $time);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        // Reset and warm-up
        cycle(1'b1, 1'b0, 4'h0, 2'b00);
        cycle(1'b1, 1'b0, 4'h0, 2'b00);
        idle(6);
        // Single requester: 0010, 0100, 1000
        hold(2'b01, 3);
        idle(2);
        // Contention from a fresh reset: 01/0010, 10/0100, 01/1000, 10/0011
        cycle(1'b1, 1'b0, 4'h0, 2'b00);
        idle(4);
        hold(2'b11, 4);
        idle(1);
        // Zero seed in READY, then first grant must be 0010
        cycle(1'b0, 1'b1, 4'h0, 2'b00);
        idle(4);
        hold(2'b01, 1);
        idle(1);
        // Seed load during a req=11 stream; resumes at 1011
        hold(2'b11, 3);
        cycle(1'b0, 1'b1, 4'h8, 2'b11);
        hold(2'b11, 7);
        // Reset mid-stream, then the reset/warm-up sequence again
        hold(2'b10, 3);
        cycle(1'b1, 1'b0, 4'h0, 2'b10);
        cycle(1'b1, 1'b0, 4'h0, 2'b00);
        idle(6);
        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            logic       r, sl;
            logic [3:0] sv;
            logic [1:0] rq;
            r  = ($urandom_range(0, 59) == 0);
            sl = ($urandom_range(0, 19) == 0);
            sv = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            rq = 2'($urandom_range(0, 3));
            cycle(r, sl, sv, rq);
        end
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected grants never seen", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_share_ctrl.md
# lfsr_share_ctrl

Sequencing and arbitration controller for the 4-bit XOR-feedback LFSR used as the lab pseudo-random source. It owns an internal LFSR with the standard tap arrangement, seeds it, runs a warm-up phase, and shares the generated nibbles between two requesters with round-robin arbitration. Each grant delivers exactly one fresh value. No value is ever handed to both requesters.

## Interface
Parameters:
- SEED, 4'b1111, LFSR value loaded at reset, and substituted when a zero seed is requested.
- WARMUP, 4, LFSR steps taken after reset or seed load before serving; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_load  in  1  load seed_val into the LFSR and restart warm-up.
- seed_val  in  4  seed value, sampled when seed_load=1.
- req  in  2  level requests; req[i]=1 means requester i wants one value.
- gnt  out  2  registered one-hot grant; all zeros when no grant.
- rnd  out  4  registered value delivered with the grant.
- rnd_valid  out  1  high in exactly the cycles where gnt is non-zero.
- busy  out  1  high while in WARM.

## Operation
- LFSR step, with bits q[3:0]:
  - q0 <= q3
  - q1 <= q3 ^ q0
  - q2 <= q1
  - q3 <= q2
  - The LFSR steps only when a WARM cycle runs or a grant is issued. Otherwise it holds.
- Zero seed: the all-zero state is a lock-up state. If seed_load=1 with seed_val=0, SEED is loaded instead.
- States:
  - WARM: the LFSR steps once per cycle and warm_cnt increments. When warm_cnt reaches WARMUP, go to READY. If WARMUP=0, WARM is left after zero cycles, so seed_load or reset goes directly to READY.
  - READY: if req != 0, issue one grant this edge. The LFSR steps and the priority pointer updates. Otherwise idle and hold.
- Arbitration:
  - ptr selects the preferred requester; reset value is 0.
  - Both requesting: grant req[ptr].
  - One requesting: grant that requester, whatever ptr is.
  - After granting i, ptr <= ~i.
- Grant issue: at the edge that accepts a request, the following are registered:
  - gnt <= one-hot(i)
  - rnd <= current (pre-step) LFSR value
  - rnd_valid <= 1
  - LFSR <= stepped value
- Outputs when no grant is issued: gnt=0 and rnd_valid=0. rnd holds its last value.
- Requests are level-sensitive. A requester holding req high receives a new value on every edge it wins. It must drop req in the cycle it sees its gnt if it wants only one value.
- seed_load has priority over everything except rst:
  - It loads the seed, clears warm_cnt and enters WARM (or READY if WARMUP=0).
  - No grant is issued at that edge.
  - ptr is unchanged.
- Reset values:
  - LFSR=SEED, warm_cnt=0, ptr=0
  - gnt=2'b00, rnd=4'h0, rnd_valid=0
  - busy=1, or 0 if WARMUP=0
  - state WARM, or READY if WARMUP=0

## Timing
- Grant latency: the request is sampled at edge N; gnt and rnd are valid in the cycle after edge N. Throughput is one value per cycle.
- Warm-up: after rst is released, busy stays high for exactly WARMUP cycles. The first grant can occur at the edge following the last WARM cycle.
- The LFSR value in READY after warm-up with SEED=1111 and WARMUP=4 is 0010. The step sequence from 1111 is 1101, 1001, 0001, 0010, 0100, 1000, 0011, …
- rst asserted mid-operation: at the next edge, all state returns to reset values and any gnt in flight is dropped.
- req changing while busy=1 has no effect. Requests are not queued.
- busy is derived from the state register, with no combinational path from inputs.

## Test plan
- Reset and warm-up: hold rst for 2 cycles, then release with req=00. Required: busy=1 for 4 cycles, then 0; gnt=00 and rnd_valid=0 throughout.
- Single requester: after warm-up, hold req=01 for 3 cycles. Required: gnt=01 on 3 consecutive cycles with rnd=0010, 0100, 1000.
- Contention: after warm-up, hold req=11 for 4 cycles. Required: gnt=01, 10, 01, 10 with rnd=0010, 0100, 1000, 0011.
- Zero seed: pulse seed_load with seed_val=0000 in READY. Required: no grant that cycle, busy=1 for 4 cycles, and the first later grant has rnd=0010.
- Seed during grant stream: with req=11 streaming, pulse seed_load with seed_val=1000.
  - Required at the load edge: gnt=00.
  - Required during warm-up: busy high for 4 cycles.
  - Required afterwards: grants resume from the value 4 steps after 1000 (0011→0110→1100→1011), i.e. the first rnd is 1011, granted to the requester indicated by the preserved ptr.
- Reset mid-stream: assert rst while req=10 is streaming. Required: gnt=00 and rnd=0000 at the next edge, and the post-release sequence is identical to the reset and warm-up test.
